// File: rtl/pkt_buf_pkg.sv
// Shared constants and types for the centralized packet buffer datapath.
package pkt_buf_pkg;

  localparam int NUM_PORTS = 9;
  localparam int DATA_W    = 134;
  localparam int ADDR_W    = 16;
  localparam int RAM_LAT   = 2;
  localparam int PORT_W    = 4;

  // Line flag carried in the top two bits of every buffer line
  typedef enum logic [1:0] {
    LINE_HEAD = 2'b01,
    LINE_TAIL = 2'b10,
    LINE_MID  = 2'b11
  } line_flag_e;

  // One stage of the read-latency tracking pipe
  typedef struct packed {
    logic              vld;
    logic [PORT_W-1:0] port;
  } lat_stage_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] idx);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      oh[k] = (idx == PORT_W'(k));
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector: first requester at or after ptr.
module rr_arbiter
  import pkt_buf_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int IW = PORT_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] start;
  logic [IW:0]   sum;
  logic [IW-1:0] kk;

  // An out-of-range pointer restarts the search at port 0
  always_comb begin
    start = (ptr < IW'(N)) ? ptr : '0;
  end

  // Walk the ports once from start, wrapping, and keep the first hit
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    kk      = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, start} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      kk = sum[IW-1:0];
      if (!gnt_any && req[kk]) begin
        gnt_any = 1'b1;
        gnt_idx = kk;
        gnt[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_read_arbiter.sv
// Packet buffer read-port arbiter: round-robin grant across output-port
// readers, RAM read strobe, and latency-tracked steering of returned lines.
module pkt_read_arbiter
  import pkt_buf_pkg::*;
(
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        i_rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] iv_rd_bufadd,
  output logic [NUM_PORTS-1:0]        o_rd_ack,
  input  logic                        i_ram_rd_en,
  output logic                        o_ram_rd,
  output logic [ADDR_W-1:0]           ov_ram_rdaddr,
  input  logic [DATA_W-1:0]           iv_ram_rddata,
  output logic [DATA_W-1:0]           ov_pkt,
  output logic [NUM_PORTS-1:0]        ov_pkt_valid,
  output logic [PORT_W-1:0]           ov_grant_port
);

  logic [PORT_W-1:0]    rr_ptr;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] gnt_oh;
  logic [PORT_W-1:0]    gnt_idx;
  logic                 gnt_any;
  logic [ADDR_W-1:0]    gnt_addr;
  lat_stage_t           lat_pipe [RAM_LAT+1];

  // A port acked this cycle is masked so its held request is not granted twice
  assign elig = i_ram_rd_en ? (i_rd_req & ~o_rd_ack) : '0;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (PORT_W)
  ) u_rr (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Pick the granted port's line address
  always_comb begin
    gnt_addr = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt_oh[k]) begin
        gnt_addr = iv_rd_bufadd[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Register the grant: ack pulse, RAM strobe/address and pointer advance
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_rd_ack      <= '0;
      o_ram_rd      <= 1'b0;
      ov_ram_rdaddr <= '0;
      ov_grant_port <= '0;
      rr_ptr        <= '0;
    end else begin
      o_rd_ack <= gnt_oh;
      o_ram_rd <= gnt_any;
      if (gnt_any) begin
        ov_ram_rdaddr <= gnt_addr;
        ov_grant_port <= gnt_idx;
        rr_ptr        <= (gnt_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);
      end
    end
  end

  // Latency pipe: stage s is valid during the s-th cycle after the strobe
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int s = 0; s <= RAM_LAT; s++) begin
        lat_pipe[s] <= '0;
      end
    end else begin
      lat_pipe[0].vld  <= gnt_any;
      lat_pipe[0].port <= gnt_idx;
      for (int s = 1; s <= RAM_LAT; s++) begin
        lat_pipe[s] <= lat_pipe[s-1];
      end
    end
  end

  // Capture returning RAM data and tag it with the owning port
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ov_pkt       <= '0;
      ov_pkt_valid <= '0;
    end else if (lat_pipe[RAM_LAT].vld) begin
      ov_pkt       <= iv_ram_rddata;
      ov_pkt_valid <= port_onehot(lat_pipe[RAM_LAT].port);
    end else begin
      ov_pkt       <= '0;
      ov_pkt_valid <= '0;
    end
  end

endmodule

// File: tb/tb_pkt_read_arbiter.sv
// Bench for pkt_read_arbiter: randomized port traffic, a reference model of
// the round-robin read arbiter, a RAM model and a return scoreboard.
module tb_pkt_read_arbiter;
  import pkt_buf_pkg::*;

  localparam int N = NUM_PORTS;

  logic                   clk_sys = 1'b0;
  logic                   reset;
  logic [N-1:0]           i_rd_req;
  logic [N*ADDR_W-1:0]    iv_rd_bufadd;
  logic [N-1:0]           o_rd_ack;
  logic                   i_ram_rd_en;
  logic                   o_ram_rd;
  logic [ADDR_W-1:0]      ov_ram_rdaddr;
  logic [DATA_W-1:0]      iv_ram_rddata;
  logic [DATA_W-1:0]      ov_pkt;
  logic [N-1:0]           ov_pkt_valid;
  logic [PORT_W-1:0]      ov_grant_port;

  pkt_read_arbiter dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .i_rd_req      (i_rd_req),
    .iv_rd_bufadd  (iv_rd_bufadd),
    .o_rd_ack      (o_rd_ack),
    .i_ram_rd_en   (i_ram_rd_en),
    .o_ram_rd      (o_ram_rd),
    .ov_ram_rdaddr (ov_ram_rdaddr),
    .iv_ram_rddata (iv_ram_rddata),
    .ov_pkt        (ov_pkt),
    .ov_pkt_valid  (ov_pkt_valid),
    .ov_grant_port (ov_grant_port)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Content the RAM model holds at each line address
  function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    logic [1:0] f;
    f = (a[1:0] == 2'd0) ? 2'(LINE_HEAD) : (a[1:0] == 2'd1) ? 2'(LINE_MID) : 2'(LINE_TAIL);
    return {f, a[3:0], 8'hA5, a, ~a, a ^ 16'h5A5A, {4{a}}, 8'h3C};
  endfunction

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    int                due;
  } ret_t;

  ret_t sb_q[$];

  // Reference model state
  int                m_ptr;
  logic [N-1:0]      exp_ack;
  logic              exp_rd;
  logic [ADDR_W-1:0] exp_addr;
  logic [3:0]        exp_gp;
  bit                chk_en = 1'b0;
  logic [N-1:0]      m_elig;
  bit                m_found;
  int                m_g;
  int                m_k;
  logic [ADDR_W:0]   ram_pipe [RAM_LAT+1];

  // RAM model and reference arbiter, evaluated on the inputs of the current cycle
  always @(negedge clk_sys) begin
    #1;
    for (int s = RAM_LAT; s > 0; s--) ram_pipe[s] = ram_pipe[s-1];
    ram_pipe[0] = {o_ram_rd, ov_ram_rdaddr};
    if (ram_pipe[RAM_LAT][ADDR_W] === 1'b1)
      iv_ram_rddata = line_of(ram_pipe[RAM_LAT][ADDR_W-1:0]);
    else
      iv_ram_rddata = {$urandom(), $urandom(), $urandom(), $urandom(), 6'($urandom())};

    if (reset) begin
      exp_ack  = '0;
      exp_rd   = 1'b0;
      exp_addr = '0;
      exp_gp   = '0;
      m_ptr    = 0;
      sb_q.delete();
      chk_en   = 1'b1;
    end else begin
      m_elig  = i_rd_req & ~exp_ack;
      m_found = 1'b0;
      m_g     = 0;
      if (i_ram_rd_en) begin
        for (int i = 0; i < N; i++) begin
          m_k = (m_ptr + i) % N;
          if (!m_found && m_elig[m_k]) begin
            m_found = 1'b1;
            m_g     = m_k;
          end
        end
      end
      if (m_found) begin
        exp_ack       = '0;
        exp_ack[m_g]  = 1'b1;
        exp_rd        = 1'b1;
        exp_addr      = iv_rd_bufadd[m_g*ADDR_W +: ADDR_W];
        exp_gp        = 4'(m_g);
        m_ptr         = (m_g + 1) % N;
        sb_q.push_back('{m_g, line_of(exp_addr), cyc + RAM_LAT + 2});
      end else begin
        exp_ack = '0;
        exp_rd  = 1'b0;
      end
    end
  end

  // Monitor: grant outputs every cycle, returned lines against the scoreboard
  ret_t r;
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("rd_ack", o_rd_ack, exp_ack);
      chk("ram_rd", o_ram_rd, exp_rd);
      chk("ram_rdaddr", ov_ram_rdaddr, exp_addr);
      chk("grant_port", ov_grant_port, exp_gp);
      if (ov_pkt_valid !== '0) begin
        if (sb_q.size() == 0) begin
          chk("ret_unexpected", ov_pkt_valid, '0);
        end else begin
          r = sb_q.pop_front();
          chk("ret_valid", ov_pkt_valid, port_onehot(4'(r.port)));
          chk("ret_data", ov_pkt, r.data);
          chk("ret_cycle", cyc, r.due);
        end
      end else begin
        chk("idle_pkt", ov_pkt, '0);
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
          r = sb_q.pop_front();
          chk("ret_missing", ov_pkt_valid, port_onehot(4'(r.port)));
        end
      end
    end
  end

  // Port driver controls
  logic [N-1:0] allow_mask;
  logic [N-1:0] stream_mask;
  int           p_req;
  bit           en_rand;

  task automatic step();
    @(posedge clk_sys);
    #1;
    for (int k = 0; k < N; k++) begin
      if (i_rd_req[k] && o_rd_ack[k]) begin
        if (stream_mask[k]) iv_rd_bufadd[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
        else                i_rd_req[k] = 1'b0;
      end else if (!i_rd_req[k] && allow_mask[k] && $urandom_range(0, 99) < p_req) begin
        i_rd_req[k] = 1'b1;
        iv_rd_bufadd[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom());
      end
    end
    if (en_rand) i_ram_rd_en = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    for (int s = 0; s <= RAM_LAT; s++) ram_pipe[s] = '0;
    reset         = 1'b1;
    i_rd_req      = '0;
    iv_rd_bufadd  = '0;
    i_ram_rd_en   = 1'b1;
    iv_ram_rddata = '0;
    allow_mask    = '0;
    stream_mask   = '0;
    p_req         = 0;
    en_rand       = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();

    // single port 3 reading line 0x0010
    iv_rd_bufadd[3*ADDR_W +: ADDR_W] = 16'h0010;
    i_rd_req[3] = 1'b1;
    repeat (8) step();

    // every port streaming: strict rotation
    allow_mask  = '1;
    stream_mask = '1;
    p_req       = 100;
    repeat (25) step();

    // RAM read port unavailable for 4 cycles with reads in flight
    i_ram_rd_en = 1'b0;
    repeat (4) step();
    i_ram_rd_en = 1'b1;
    repeat (12) step();

    // reset with reads in flight
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();

    // drain
    allow_mask  = '0;
    stream_mask = '0;
    repeat (14) step();

    // grant port 4 to park the pointer at 5, then ports 2 and 7 together
    iv_rd_bufadd[4*ADDR_W +: ADDR_W] = 16'h0444;
    i_rd_req[4] = 1'b1;
    repeat (6) step();
    iv_rd_bufadd[2*ADDR_W +: ADDR_W] = 16'h0222;
    iv_rd_bufadd[7*ADDR_W +: ADDR_W] = 16'h0777;
    i_rd_req[2] = 1'b1;
    i_rd_req[7] = 1'b1;
    repeat (8) step();

    // port 0 back-to-back with a new address after each ack
    stream_mask = 9'h001;
    iv_rd_bufadd[0 +: ADDR_W] = 16'h1000;
    i_rd_req[0] = 1'b1;
    repeat (12) step();
    stream_mask = '0;
    repeat (4) step();

    // random traffic, random RAM availability, occasional reset
    allow_mask = '1;
    p_req      = 30;
    en_rand    = 1'b1;
    repeat (500) begin
      stream_mask = N'($urandom());
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset       = 1'b0;
    en_rand     = 1'b0;
    i_ram_rd_en = 1'b1;
    allow_mask  = '0;
    stream_mask = '0;
    repeat (20) step();

    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
